conway_generation_stepper: RTL
==============================

# conway_generation_stepper

Computes one Game-of-Life generation per `start` pulse. Streams the current-generation grid out of game memory in raster order and keeps a two-row line buffer plus a 3x3 window. Writes every next-generation cell into the other game buffer. Sits directly upstream of the iteration writer: its `done` pulse triggers the writer's `grab_data`, and the writer then renders the freshly written buffer into the framebuffer.

## Interface
- `GRID_W`, default 80: grid width in cells (1..4095).
- `GRID_H`, default 60: grid height in cells (1..4095).
- `clk` input 1: single clock; all logic rising-edge.
- `rst_n` input 1: synchronous reset, active-low.
- `start` input 1: begin one generation; sampled only in IDLE.
- `rd_en` output 1: read request to the current-generation memory.
- `rd_x`, `rd_y` output 12 each: read address.
- `rd_data` input 1: cell state, valid exactly one cycle after `rd_en`.
- `wr_en` output 1: write strobe to the next-generation memory.
- `wr_x`, `wr_y` output 12 each: write address.
- `wr_data` output 1: next-generation cell state.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse when the last write has been issued.
- `live_count` output 16: number of live cells written in the last completed generation.
- `generation` output 16: count of completed generations; wraps at 65535 -> 0.

## Operation
- States:
  - IDLE -> SCAN when `start` is high.
  - SCAN -> DRAIN after the final scan position.
  - DRAIN (2 cycles) -> DONE.
  - DONE (1 cycle) -> IDLE.
- SCAN walks scan positions `(sx,sy)` with sx 0..GRID_W and sy 0..GRID_H, raster order, one per cycle.
- Reads at scan positions:
  - For sx<GRID_W and sy<GRID_H: `rd_en`=1 and `rd_x/rd_y` = `(sx,sy)`.
  - Otherwise: `rd_en`=0, and the cell is taken as dead.
- Cells outside the grid are dead. There is no toroidal wrap.
- Window handling:
  - Each returned cell shifts into the window's right column.
  - The two rows above come from the line buffer at column sx.
  - At sx=0 the window's left and centre columns are forced dead.
  - For sy=0 the rows above are forced dead.
- Cell output:
  - Scan position `(sx,sy)` with sx>=1 and sy>=1 produces the cell `(sx-1,sy-1)` from the window centre.
  - `n` is the count of the 8 neighbours (4 bits, 0..8).
  - Next state = (n==3) | (centre & n==2).
- Exactly GRID_W*GRID_H writes occur per generation, in raster order.
- `live_count`:
  - An internal accumulator clears at the SCAN entry and adds each `wr_data`.
  - It copies to `live_count` in DONE.
  - It saturates at 65535.
- `generation` increments in DONE.
- `start` while not IDLE is ignored, with no queuing.

## Timing
- Reset values (all outputs): `rd_en`, `wr_en`, `busy`, `done` = 0; all addresses, `wr_data`, `live_count`, `generation` = 0. The state machine is in IDLE.
- Acceptance:
  - `start` high at edge E0 in IDLE puts the block in SCAN from E0.
  - `busy` is high in the following cycle.
  - The first read is issued in that same cycle.
- Pipeline per scan position:
  - Stage 0: the read is issued.
  - Stage 1: `rd_data` arrives and the window and line buffer update.
  - Stage 2: `wr_en/wr_x/wr_y/wr_data` are registered and valid.
- The write for scan position `(sx,sy)` appears 2 cycles after that position is issued.
- Cycle budget:
  - SCAN: (GRID_W+1)*(GRID_H+1) cycles.
  - DRAIN: 2 cycles, in which the last write appears.
  - `done` pulses the cycle after the last write. `busy` is low in that same cycle.
  - Total from start edge to `done`: (GRID_W+1)(GRID_H+1)+3 cycles; 4944 at default.
- Write format: `wr_en` is a one-cycle strobe per cell and never stalls. The memory must accept one write per cycle.
- Reset mid-operation:
  - `rst_n` low at any edge returns the block to IDLE at that edge.
  - `rd_en`/`wr_en`/`busy` are 0 from that edge onward, and no partial `done` is produced.
  - `generation` and `live_count` reset.

## Structure
- Shared package `conway_pkg`, used by the iteration writer as well, holds:
  - `COORD_W`=12.
  - The state enum (IDLE, SCAN, DRAIN, DONE).
  - A `life_rule(centre, n)` function.
- Sub-module `conway_line_buffer`:
  - GRID_W-deep, 2-bit-wide shift/RAM.
  - Read-before-write at the same column; returns {row y-2, row y-1}.
- Buffer selection (which memory is current) stays outside this block, in the top-level, toggled on `done`.

## Test plan
- Blinker with live cells (10,9),(10,10),(10,11) -> live writes only at (9,10),(10,10),(11,10); `live_count`=3; `done` 4944 cycles after start.
- Block at corner cells (0,0),(1,0),(0,1),(1,1) -> same 4 cells live and everything else 0; confirms dead border, no wrap.
- Single live cell at (79,59) -> every write 0, `live_count`=0, exactly 4800 `wr_en` strobes, addresses strictly raster.
- Glider run for 4 generations -> pattern shifted by (+1,+1); `generation`=4.
- `start` held high throughout -> generations run back-to-back, one idle cycle between each `done` and the next SCAN; no extra writes.
- `rst_n` low at scan position (40,20) -> next cycle `busy`=0, `wr_en`=0, no `done`; a new `start` then completes normally.

Source files
------------

// File: rtl/conway_pkg.sv
// Purpose : shared Game-of-Life definitions for the generation stepper and the iteration writer.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: COORD_W coordinate width, stepper state encoding, life_rule() next-state function.
package conway_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // B3/S23: born with exactly 3 neighbours, survives with 2 or 3.
  function automatic logic life_rule(input logic centre, input logic [3:0] n);
    return (n == 4'd3) || (centre && (n == 4'd2));
  endfunction

endpackage

// File: rtl/conway_generation_stepper_if.sv
// Purpose : game-memory port bundle: read port to the current-generation buffer,
//           write port to the next-generation buffer.
// Latency : rd_data is valid exactly one cycle after rd_en; writes take effect on the strobe.
// Backpr. : none; the memory must take one read and one write every cycle.
// Modports: master = stepper (drives addresses/strobes), slave = memory (drives rd_data).
interface conway_generation_stepper_if;
  import conway_pkg::*;

  logic               rd_en;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               rd_data;

  logic               wr_en;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic               wr_data;

  modport master (
    output rd_en, rd_x, rd_y,
    input  rd_data,
    output wr_en, wr_x, wr_y, wr_data
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    output rd_data,
    input  wr_en, wr_x, wr_y, wr_data
  );

endinterface

// File: rtl/conway_line_buffer.sv
// Purpose : GRID_W-deep, 2-bit-wide column store holding the two grid rows above the scan row.
// Latency : combinational read, write lands on the next rising edge (read-before-write per column).
// Backpr. : none; one read and one write per cycle.
// Ports   : rd_col -> rd_dat = {row y-2, row y-1}; wr_en/wr_col/wr_dat = {row y-1, row y}.
module conway_line_buffer
  import conway_pkg::*;
#(
  parameter int GRID_W = 80
) (
  input  logic               clk,
  input  logic [COORD_W-1:0] rd_col,
  output logic [1:0]         rd_dat,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_col,
  input  logic [1:0]         wr_dat
);

  localparam int AW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [COORD_W-1:0] DEPTH = COORD_W'(GRID_W);

  logic [1:0] mem_q [GRID_W];

  // Columns past the right edge read as dead so the caller never sees stale data there.
  always_comb begin
    rd_dat = 2'b00;
    if (rd_col < DEPTH) begin
      rd_dat = mem_q[rd_col[AW-1:0]];
    end
  end

  // No reset: every column is rewritten on row 0 of each generation before it is read.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_col < DEPTH)) begin
      mem_q[wr_col[AW-1:0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/conway_generation_stepper.sv
// Purpose : computes one Game-of-Life generation per start pulse (dead border, no wrap).
// Latency : (GRID_W+1)*(GRID_H+1)+3 cycles from the start edge to done; writes trail reads by 2.
// Backpr. : none; issues one read and at most one write per cycle and never stalls.
// Ports   : clk, rst_n (sync, active-low), start; mem = read/write game-memory bundle;
//           busy, done pulse, live_count (live cells of last generation), generation counter.
module conway_generation_stepper
  import conway_pkg::*;
#(
  parameter int GRID_W = 80,
  parameter int GRID_H = 60
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  conway_generation_stepper_if.master  mem,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  live_count,
  output logic [15:0]                  generation
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SCAN  = ST_SCAN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  // The scan runs one position past each edge so the last column/row can leave the window.
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(GRID_H);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

  // Control
  logic [1:0]         state_q, state_d;
  logic               drain_q, drain_d;
  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;

  // Stage 1: the scan position whose read data arrives this cycle
  logic               s1_vld_q, s1_vld_d;
  logic               s1_rd_q, s1_rd_d;
  logic [COORD_W-1:0] s1_x_q, s1_x_d;
  logic [COORD_W-1:0] s1_y_q, s1_y_d;

  // 3x3 window, each column packed {row y-2, row y-1, row y}
  logic [2:0]         col_l_q, col_l_d;
  logic [2:0]         col_c_q, col_c_d;
  logic [2:0]         col_r_q, col_r_d;

  // Stage 2: registered write port
  logic               wr_en_q, wr_en_d;
  logic [COORD_W-1:0] wr_x_q, wr_x_d;
  logic [COORD_W-1:0] wr_y_q, wr_y_d;
  logic               wr_data_q, wr_data_d;

  // Statistics
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        live_q, live_d;
  logic [15:0]        gen_q, gen_d;

  // Combinational helpers
  logic               scan_act;
  logic               rd_issue;
  logic               cell_new;
  logic [1:0]         lb_rd_dat;
  logic [1:0]         above;
  logic               lb_wr_en;
  logic [1:0]         lb_wr_dat;
  logic [7:0]         nbr;
  logic [3:0]         n_cnt;

  // ---------------------------------------------------------------------------
  // Scan FSM, stage-0 read issue, statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    live_d   = live_q;
    gen_d    = gen_q;
    acc_d    = acc_q;

    scan_act = (state_q == SCAN);
    rd_issue = scan_act && (sx_q < LAST_X) && (sy_q < LAST_Y);

    s1_vld_d = scan_act;
    s1_rd_d  = rd_issue;
    s1_x_d   = sx_q;
    s1_y_d   = sy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      SCAN: begin
        if (sx_q == LAST_X) begin
          sx_d = '0;
          if (sy_q == LAST_Y) begin
            state_d = DRAIN;
            sy_d    = '0;
            drain_d = 1'b0;
          end else begin
            sy_d = sy_q + ONE;
          end
        end else begin
          sx_d = sx_q + ONE;
        end
      end
      DRAIN: begin
        // Two cycles: the last scan position passes stage 1, then its write is on the port.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
          // The accumulator already holds the final write, so publish alongside done.
          live_d  = acc_q;
          gen_d   = gen_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Count cells as they are registered into the write port; saturate rather than wrap.
    if ((state_q == IDLE) && start) begin
      acc_d = '0;
    end else if (wr_en_d && wr_data_d && (acc_q != 16'hFFFF)) begin
      acc_d = acc_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: window / line-buffer update and next-state evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    // rd_data is only meaningful when a read was actually issued for this position.
    cell_new  = s1_rd_q & mem.rd_data;
    // Row 0 has nothing above it; the buffer may still hold the previous generation.
    above     = (s1_y_q != '0) ? lb_rd_dat : 2'b00;
    lb_wr_en  = s1_vld_q && (s1_x_q < LAST_X);
    lb_wr_dat = {above[0], cell_new};

    col_l_d = col_l_q;
    col_c_d = col_c_q;
    col_r_d = col_r_q;
    if (s1_vld_q) begin
      col_r_d = {above, cell_new};
      if (s1_x_q == '0) begin
        // Left border: the columns that would shift in belong to the previous row.
        col_l_d = 3'b000;
        col_c_d = 3'b000;
      end else begin
        col_l_d = col_c_q;
        col_c_d = col_r_q;
      end
    end

    nbr   = {col_l_d, col_r_d, col_c_d[2], col_c_d[0]};
    n_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_cnt = n_cnt + {3'b000, nbr[i]};
    end

    // The window centre is cell (sx-1, sy-1); it exists only once both are >= 1.
    wr_en_d   = s1_vld_q && (s1_x_q != '0) && (s1_y_q != '0);
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_data_d = 1'b0;
    if (wr_en_d) begin
      wr_x_d    = s1_x_q - ONE;
      wr_y_d    = s1_y_q - ONE;
      wr_data_d = life_rule(col_c_d[1], n_cnt);
    end
  end

  conway_line_buffer #(
    .GRID_W (GRID_W)
  ) u_line_buffer (
    .clk    (clk),
    .rd_col (s1_x_q),
    .rd_dat (lb_rd_dat),
    .wr_en  (lb_wr_en),
    .wr_col (s1_x_q),
    .wr_dat (lb_wr_dat)
  );

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drain_q   <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_rd_q   <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      col_l_q   <= 3'b000;
      col_c_q   <= 3'b000;
      col_r_q   <= 3'b000;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= 1'b0;
      acc_q     <= '0;
      live_q    <= '0;
      gen_q     <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      s1_vld_q  <= s1_vld_d;
      s1_rd_q   <= s1_rd_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      col_l_q   <= col_l_d;
      col_c_q   <= col_c_d;
      col_r_q   <= col_r_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_data_q <= wr_data_d;
      acc_q     <= acc_d;
      live_q    <= live_d;
      gen_q     <= gen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem.rd_en   = rd_issue;
  assign mem.rd_x    = sx_q;
  assign mem.rd_y    = sy_q;
  assign mem.wr_en   = wr_en_q;
  assign mem.wr_x    = wr_x_q;
  assign mem.wr_y    = wr_y_q;
  assign mem.wr_data = wr_data_q;

  assign busy        = (state_q == SCAN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign live_count  = live_q;
  assign generation  = gen_q;

endmodule
